// File: rtl/id_pipe_stage.sv
// Registered RV32I decode stage: decodes, reads/forwards operands, resolves
// branches and jumps, interlocks load-use, and holds results in an ID/EX register.
module id_pipe_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int AOP_W   = 8,
  parameter int ASEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    if_valid_i,
  output logic                    if_ready_o,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             inst_i,
  output logic [4:0]              rf_raddr1_o,
  output logic [4:0]              rf_raddr2_o,
  input  logic [XLEN-1:0]         rf_rdata1_i,
  input  logic [XLEN-1:0]         rf_rdata2_i,
  input  logic [NUM_FWD-1:0]      fwd_wen_i,
  input  logic [5*NUM_FWD-1:0]    fwd_waddr_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [AOP_W-1:0]        aluop_o,
  output logic [ASEL_W-1:0]       alusel_o,
  output logic [XLEN-1:0]         op1_o,
  output logic [XLEN-1:0]         op2_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [XLEN-1:0]         link_addr_o,
  output logic [4:0]              wd_o,
  output logic                    wreg_o,
  output logic [31:0]             inst_o,
  output logic                    illegal_o,
  output logic                    redirect_o,
  output logic [XLEN-1:0]         redirect_pc_o
);

  localparam logic [AOP_W-1:0] EXE_NOP_OP  = AOP_W'(8'h00);
  localparam logic [AOP_W-1:0] EXE_ADD_OP  = AOP_W'(8'h20);
  localparam logic [AOP_W-1:0] EXE_SUB_OP  = AOP_W'(8'h22);
  localparam logic [AOP_W-1:0] EXE_SLT_OP  = AOP_W'(8'h2A);
  localparam logic [AOP_W-1:0] EXE_SLTU_OP = AOP_W'(8'h2B);
  localparam logic [AOP_W-1:0] EXE_AND_OP  = AOP_W'(8'h24);
  localparam logic [AOP_W-1:0] EXE_OR_OP   = AOP_W'(8'h25);
  localparam logic [AOP_W-1:0] EXE_XOR_OP  = AOP_W'(8'h26);
  localparam logic [AOP_W-1:0] EXE_SLL_OP  = AOP_W'(8'h7C);
  localparam logic [AOP_W-1:0] EXE_SRL_OP  = AOP_W'(8'h02);
  localparam logic [AOP_W-1:0] EXE_SRA_OP  = AOP_W'(8'h03);
  localparam logic [AOP_W-1:0] EXE_JAL_OP  = AOP_W'(8'h50);
  localparam logic [AOP_W-1:0] EXE_JALR_OP = AOP_W'(8'h09);
  localparam logic [AOP_W-1:0] EXE_BEQ_OP  = AOP_W'(8'h51);
  localparam logic [AOP_W-1:0] EXE_BNE_OP  = AOP_W'(8'h52);
  localparam logic [AOP_W-1:0] EXE_BLT_OP  = AOP_W'(8'h53);
  localparam logic [AOP_W-1:0] EXE_BGE_OP  = AOP_W'(8'h54);
  localparam logic [AOP_W-1:0] EXE_BLTU_OP = AOP_W'(8'h55);
  localparam logic [AOP_W-1:0] EXE_BGEU_OP = AOP_W'(8'h56);
  localparam logic [AOP_W-1:0] EXE_LB_OP   = AOP_W'(8'hE0);
  localparam logic [AOP_W-1:0] EXE_LH_OP   = AOP_W'(8'hE1);
  localparam logic [AOP_W-1:0] EXE_LW_OP   = AOP_W'(8'hE3);
  localparam logic [AOP_W-1:0] EXE_LBU_OP  = AOP_W'(8'hE4);
  localparam logic [AOP_W-1:0] EXE_LHU_OP  = AOP_W'(8'hE5);
  localparam logic [AOP_W-1:0] EXE_SB_OP   = AOP_W'(8'hE8);
  localparam logic [AOP_W-1:0] EXE_SH_OP   = AOP_W'(8'hE9);
  localparam logic [AOP_W-1:0] EXE_SW_OP   = AOP_W'(8'hEB);

  localparam logic [ASEL_W-1:0] EXE_RES_NOP         = ASEL_W'(3'd0);
  localparam logic [ASEL_W-1:0] EXE_RES_LOGIC       = ASEL_W'(3'd1);
  localparam logic [ASEL_W-1:0] EXE_RES_SHIFT       = ASEL_W'(3'd2);
  localparam logic [ASEL_W-1:0] EXE_RES_ARITHMETIC  = ASEL_W'(3'd4);
  localparam logic [ASEL_W-1:0] EXE_RES_JUMP_BRANCH = ASEL_W'(3'd6);
  localparam logic [ASEL_W-1:0] EXE_RES_LOAD_STORE  = ASEL_W'(3'd7);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic [XLEN-1:0] rs1_val, rs2_val, jalr_sum;

  logic [AOP_W-1:0]  d_aluop;
  logic [ASEL_W-1:0] d_alusel;
  logic [XLEN-1:0]   d_op1, d_op2, d_imm, d_target;
  logic              d_wreg, d_legal, d_load, d_taken, uses_rs1, uses_rs2;

  logic            ld_pend, ex_is_load;
  logic [4:0]      ld_rd;
  logic            stall, accept;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];

  assign rf_raddr1_o = rs1;
  assign rf_raddr2_o = rs2;

  assign imm_i = XLEN'($signed(inst_i[31:20]));
  assign imm_s = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
  assign imm_b = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst_i[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
  assign shamt = XLEN'(inst_i[24:20]);

  // Scan oldest to youngest so the lowest-index matching source wins; x0 always reads zero.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    logic [XLEN-1:0] v;
    v = rf;
    for (int unsigned k = NUM_FWD; k > 0; k--) begin
      if (fwd_wen_i[k-1] && fwd_waddr_i[5*(k-1) +: 5] == rs)
        v = fwd_wdata_i[XLEN*(k-1) +: XLEN];
    end
    if (rs == 5'd0)
      v = '0;
    return v;
  endfunction

  // Operand select with forwarding
  always_comb begin
    rs1_val  = fwd_sel(rs1, rf_rdata1_i);
    rs2_val  = fwd_sel(rs2, rf_rdata2_i);
    jalr_sum = rs1_val + imm_i;
  end

  // Instruction decode, branch resolution and jump target
  always_comb begin
    d_aluop  = EXE_NOP_OP;
    d_alusel = EXE_RES_NOP;
    d_op1    = '0;
    d_op2    = '0;
    d_imm    = '0;
    d_target = '0;
    d_wreg   = 1'b0;
    d_legal  = 1'b1;
    d_load   = 1'b0;
    d_taken  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d_aluop = EXE_ADD_OP; d_alusel = EXE_RES_ARITHMETIC;
        d_op2 = imm_u; d_imm = imm_u; d_wreg = 1'b1;
      end
      OPC_AUIPC: begin
        d_aluop = EXE_ADD_OP; d_alusel = EXE_RES_ARITHMETIC;
        d_op1 = pc_i; d_op2 = imm_u; d_imm = imm_u; d_wreg = 1'b1;
      end
      OPC_JAL: begin
        d_aluop = EXE_JAL_OP; d_alusel = EXE_RES_JUMP_BRANCH;
        d_op1 = pc_i; d_op2 = imm_j; d_imm = imm_j; d_wreg = 1'b1;
        d_taken = 1'b1; d_target = pc_i + imm_j;
      end
      OPC_JALR: begin
        d_legal = (funct3 == 3'b000);
        d_aluop = EXE_JALR_OP; d_alusel = EXE_RES_JUMP_BRANCH;
        d_op1 = rs1_val; d_op2 = imm_i; d_imm = imm_i; d_wreg = 1'b1;
        uses_rs1 = 1'b1;
        d_taken = 1'b1; d_target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OPC_BRANCH: begin
        d_alusel = EXE_RES_JUMP_BRANCH;
        d_op1 = rs1_val; d_op2 = rs2_val; d_imm = imm_b;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        d_target = pc_i + imm_b;
        case (funct3)
          3'b000: begin d_aluop = EXE_BEQ_OP;  d_taken = (rs1_val == rs2_val); end
          3'b001: begin d_aluop = EXE_BNE_OP;  d_taken = (rs1_val != rs2_val); end
          3'b100: begin d_aluop = EXE_BLT_OP;  d_taken = ($signed(rs1_val) <  $signed(rs2_val)); end
          3'b101: begin d_aluop = EXE_BGE_OP;  d_taken = ($signed(rs1_val) >= $signed(rs2_val)); end
          3'b110: begin d_aluop = EXE_BLTU_OP; d_taken = (rs1_val <  rs2_val); end
          3'b111: begin d_aluop = EXE_BGEU_OP; d_taken = (rs1_val >= rs2_val); end
          default: d_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d_alusel = EXE_RES_LOAD_STORE;
        d_op1 = rs1_val; d_op2 = imm_i; d_imm = imm_i; d_wreg = 1'b1;
        uses_rs1 = 1'b1; d_load = 1'b1;
        case (funct3)
          3'b000: d_aluop = EXE_LB_OP;
          3'b001: d_aluop = EXE_LH_OP;
          3'b010: d_aluop = EXE_LW_OP;
          3'b100: d_aluop = EXE_LBU_OP;
          3'b101: d_aluop = EXE_LHU_OP;
          default: d_legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d_alusel = EXE_RES_LOAD_STORE;
        d_op1 = rs1_val; d_op2 = rs2_val; d_imm = imm_s;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        case (funct3)
          3'b000: d_aluop = EXE_SB_OP;
          3'b001: d_aluop = EXE_SH_OP;
          3'b010: d_aluop = EXE_SW_OP;
          default: d_legal = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        d_op1 = rs1_val; d_op2 = imm_i; d_imm = imm_i; d_wreg = 1'b1;
        uses_rs1 = 1'b1;
        case (funct3)
          3'b000: begin d_aluop = EXE_ADD_OP;  d_alusel = EXE_RES_ARITHMETIC; end
          3'b010: begin d_aluop = EXE_SLT_OP;  d_alusel = EXE_RES_ARITHMETIC; end
          3'b011: begin d_aluop = EXE_SLTU_OP; d_alusel = EXE_RES_ARITHMETIC; end
          3'b100: begin d_aluop = EXE_XOR_OP;  d_alusel = EXE_RES_LOGIC; end
          3'b110: begin d_aluop = EXE_OR_OP;   d_alusel = EXE_RES_LOGIC; end
          3'b111: begin d_aluop = EXE_AND_OP;  d_alusel = EXE_RES_LOGIC; end
          3'b001: begin
            d_aluop = EXE_SLL_OP; d_alusel = EXE_RES_SHIFT;
            d_op2 = shamt; d_imm = shamt;
            d_legal = (funct7 == 7'b0000000);
          end
          default: begin
            d_aluop = inst_i[30] ? EXE_SRA_OP : EXE_SRL_OP; d_alusel = EXE_RES_SHIFT;
            d_op2 = shamt; d_imm = shamt;
            d_legal = !inst_i[31] && (inst_i[29:25] == 5'd0);
          end
        endcase
      end
      OPC_OP: begin
        d_op1 = rs1_val; d_op2 = rs2_val; d_wreg = 1'b1;
        uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        d_legal = (funct7 == 7'b0000000) ||
                  (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        case (funct3)
          3'b000: begin d_aluop = funct7[5] ? EXE_SUB_OP : EXE_ADD_OP; d_alusel = EXE_RES_ARITHMETIC; end
          3'b001: begin d_aluop = EXE_SLL_OP;  d_alusel = EXE_RES_SHIFT; end
          3'b010: begin d_aluop = EXE_SLT_OP;  d_alusel = EXE_RES_ARITHMETIC; end
          3'b011: begin d_aluop = EXE_SLTU_OP; d_alusel = EXE_RES_ARITHMETIC; end
          3'b100: begin d_aluop = EXE_XOR_OP;  d_alusel = EXE_RES_LOGIC; end
          3'b101: begin d_aluop = funct7[5] ? EXE_SRA_OP : EXE_SRL_OP; d_alusel = EXE_RES_SHIFT; end
          3'b110: begin d_aluop = EXE_OR_OP;   d_alusel = EXE_RES_LOGIC; end
          default: begin d_aluop = EXE_AND_OP; d_alusel = EXE_RES_LOGIC; end
        endcase
      end
      OPC_FENCE: ;
      default: d_legal = 1'b0;
    endcase
    if (!d_legal) begin
      d_aluop  = EXE_NOP_OP;
      d_alusel = EXE_RES_NOP;
      d_wreg   = 1'b0;
      d_load   = 1'b0;
      d_taken  = 1'b0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
    end
  end

  // Load-use interlock and input handshake; a pending redirect blocks the wrong-path fetch
  always_comb begin
    stall = ld_pend && (ld_rd != 5'd0) &&
            ((uses_rs1 && rs1 == ld_rd) || (uses_rs2 && rs2 == ld_rd));
    if_ready_o = !flush_i && !stall && !redirect_o && (!ex_valid_o || ex_ready_i);
    accept = if_valid_i && if_ready_o;
  end

  // ID/EX output register, redirect pulse and pending-load tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o    <= 1'b0;
      aluop_o       <= EXE_NOP_OP;
      alusel_o      <= EXE_RES_NOP;
      op1_o         <= '0;
      op2_o         <= '0;
      imm_o         <= '0;
      link_addr_o   <= '0;
      wd_o          <= '0;
      wreg_o        <= 1'b0;
      inst_o        <= '0;
      illegal_o     <= 1'b0;
      ex_is_load    <= 1'b0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
      ld_pend       <= 1'b0;
      ld_rd         <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      redirect_o <= 1'b0;
      ld_pend    <= 1'b0;
    end else begin
      redirect_o <= accept && d_taken;
      if (accept && d_taken)
        redirect_pc_o <= d_target;
      if (accept) begin
        ex_valid_o  <= 1'b1;
        aluop_o     <= d_aluop;
        alusel_o    <= d_alusel;
        op1_o       <= d_op1;
        op2_o       <= d_op2;
        imm_o       <= d_imm;
        link_addr_o <= pc_i + XLEN'(4);
        wd_o        <= rd;
        wreg_o      <= d_wreg;
        inst_o      <= inst_i;
        illegal_o   <= !d_legal;
        ex_is_load  <= d_load;
      end else if (ex_ready_i) begin
        ex_valid_o <= 1'b0;
      end
      if (ex_valid_o && ex_ready_i && ex_is_load) begin
        ld_pend <= 1'b1;
        ld_rd   <= wd_o;
      end else if (ex_ready_i) begin
        ld_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed self-checking bench for id_pipe_stage.
module tb_id_pipe_stage;

  logic        clk, rst_n, flush_i, if_valid_i, if_ready_o;
  logic [31:0] pc_i, inst_i;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o;
  logic [31:0] rf_rdata1_i, rf_rdata2_i;
  logic [1:0]  fwd_wen_i;
  logic [9:0]  fwd_waddr_i;
  logic [63:0] fwd_wdata_i;
  logic        ex_valid_o, ex_ready_i;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [31:0] op1_o, op2_o, imm_o, link_addr_o, inst_o, redirect_pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o, illegal_o, redirect_o;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_ADD   = 32'h00108133; // add  x2,x1,x1
  localparam logic [31:0] I_LW    = 32'h00022183; // lw   x3,0(x4)
  localparam logic [31:0] I_ADD3  = 32'h000182B3; // add  x5,x3,x0
  localparam logic [31:0] I_BEQ   = 32'h00108863; // beq  x1,x1,+16
  localparam logic [31:0] I_BNE   = 32'h00109863; // bne  x1,x1,+16
  localparam logic [31:0] I_JALR  = 32'hFFD100E7; // jalr x1,-3(x2)
  localparam logic [31:0] I_SLLB  = 32'h02109093; // slli x1,x1,1 with inst[25]=1
  localparam logic [31:0] I_SLLI  = 32'h00309093; // slli x1,x1,3
  localparam logic [31:0] I_SRAI  = 32'h4030D093; // srai x1,x1,3
  localparam logic [31:0] I_ADDX0 = 32'h00100333; // add  x6,x0,x1

  id_pipe_stage #(.XLEN(32), .NUM_FWD(2), .AOP_W(8), .ASEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
    .pc_i(pc_i), .inst_i(inst_i),
    .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .fwd_wen_i(fwd_wen_i), .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .aluop_o(aluop_o), .alusel_o(alusel_o),
    .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o), .link_addr_o(link_addr_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .inst_o(inst_o), .illegal_o(illegal_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic er);
    if_valid_i = v;
    pc_i       = pc;
    inst_i     = inst;
    ex_ready_i = er;
  endtask

  task automatic set_fwd(input int k, input logic wen, input logic [4:0] a, input logic [31:0] d);
    fwd_wen_i[k]          = wen;
    fwd_waddr_i[5*k +: 5] = a;
    fwd_wdata_i[32*k +: 32] = d;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    rf_rdata1_i = 32'h0; rf_rdata2_i = 32'h0;
    fwd_wen_i = '0; fwd_waddr_i = '0; fwd_wdata_i = '0;
    #3;
    chk("rst_ex_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_redirect", 32'(redirect_o), 32'd0);
    chk("rst_aluop", 32'(aluop_o), 32'h00);
    chk("rst_alusel", 32'(alusel_o), 32'd0);
    chk("rst_op1", op1_o, 32'h0);
    chk("rst_link", link_addr_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: back-to-back with forwarding, lowest-index source wins
    rf_rdata1_i = 32'hDEAD; rf_rdata2_i = 32'hDEAD;
    drive(1'b1, 32'h0, I_ADDI, 1'b1); #1;
    chk("t1_ready_addi", 32'(if_ready_o), 32'd1);
    tick();
    chk("t1_addi_valid", 32'(ex_valid_o), 32'd1);
    chk("t1_addi_op1", op1_o, 32'h0);
    chk("t1_addi_op2", op2_o, 32'd5);
    chk("t1_addi_aluop", 32'(aluop_o), 32'h20);
    chk("t1_addi_alusel", 32'(alusel_o), 32'd4);
    chk("t1_addi_wd", 32'(wd_o), 32'd1);
    chk("t1_addi_wreg", 32'(wreg_o), 32'd1);
    chk("t1_addi_link", link_addr_o, 32'h4);
    drive(1'b1, 32'h4, I_ADD, 1'b1);
    set_fwd(0, 1'b1, 5'd1, 32'd5);
    set_fwd(1, 1'b1, 5'd1, 32'd7);
    #1;
    chk("t1_ready_add", 32'(if_ready_o), 32'd1);
    tick();
    chk("t1_add_valid", 32'(ex_valid_o), 32'd1);
    chk("t1_add_op1", op1_o, 32'd5);
    chk("t1_add_op2", op2_o, 32'd5);
    chk("t1_add_inst", inst_o, I_ADD);

    // 2: load-use interlock, dependant picks the older forward
    set_fwd(0, 1'b0, 5'd0, 32'h0); set_fwd(1, 1'b0, 5'd0, 32'h0);
    rf_rdata1_i = 32'h1000;
    drive(1'b1, 32'h8, I_LW, 1'b1);
    tick();
    chk("t2_lw_aluop", 32'(aluop_o), 32'hE3);
    chk("t2_lw_alusel", 32'(alusel_o), 32'd7);
    chk("t2_lw_op1", op1_o, 32'h1000);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("t2_issue_empty", 32'(ex_valid_o), 32'd0);
    drive(1'b1, 32'hC, I_ADD3, 1'b1);
    set_fwd(0, 1'b1, 5'd3, 32'hAAAA);
    #1;
    chk("t2_raddr1", 32'(rf_raddr1_o), 32'd3);
    chk("t2_stall", 32'(if_ready_o), 32'd0);
    tick();
    chk("t2_bubble", 32'(ex_valid_o), 32'd0);
    set_fwd(0, 1'b0, 5'd0, 32'h0);
    set_fwd(1, 1'b1, 5'd3, 32'h1234);
    rf_rdata1_i = 32'h5555; rf_rdata2_i = 32'h5555;
    #1;
    chk("t2_resume", 32'(if_ready_o), 32'd1);
    tick();
    chk("t2_dep_valid", 32'(ex_valid_o), 32'd1);
    chk("t2_dep_op1", op1_o, 32'h1234);
    chk("t2_dep_op2_x0", op2_o, 32'h0);

    // 3: taken beq redirects one cycle later; equal bne does not
    set_fwd(1, 1'b0, 5'd0, 32'h0);
    rf_rdata1_i = 32'h55; rf_rdata2_i = 32'h55;
    drive(1'b1, 32'h100, I_BEQ, 1'b1);
    tick();
    chk("t3_beq_redirect", 32'(redirect_o), 32'd1);
    chk("t3_beq_target", redirect_pc_o, 32'h110);
    chk("t3_beq_aluop", 32'(aluop_o), 32'h51);
    chk("t3_beq_wreg", 32'(wreg_o), 32'd0);
    drive(1'b1, 32'h104, I_ADDI, 1'b1); #1;
    chk("t3_block_wrongpath", 32'(if_ready_o), 32'd0);
    tick();
    chk("t3_redirect_pulse", 32'(redirect_o), 32'd0);
    chk("t3_wrongpath_dropped", 32'(ex_valid_o), 32'd0);
    drive(1'b1, 32'h200, I_BNE, 1'b1);
    tick();
    chk("t3_bne_no_redirect", 32'(redirect_o), 32'd0);
    chk("t3_bne_aluop", 32'(aluop_o), 32'h52);

    // 4: jalr target clears bit 0
    rf_rdata1_i = 32'h200;
    drive(1'b1, 32'h300, I_JALR, 1'b1);
    tick();
    chk("t4_jalr_redirect", 32'(redirect_o), 32'd1);
    chk("t4_jalr_target", redirect_pc_o, 32'h1FC);
    chk("t4_jalr_link", link_addr_o, 32'h304);
    chk("t4_jalr_wd", 32'(wd_o), 32'd1);
    chk("t4_jalr_wreg", 32'(wreg_o), 32'd1);
    chk("t4_jalr_aluop", 32'(aluop_o), 32'h09);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("t4_redirect_pulse", 32'(redirect_o), 32'd0);

    // 5: EX back-pressure holds the output; flush beats accept and redirect
    drive(1'b1, 32'h400, I_ADDI, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h404, I_ADD, 1'b0); #1;
      chk("t5_hold_ready", 32'(if_ready_o), 32'd0);
      tick();
      chk("t5_hold_valid", 32'(ex_valid_o), 32'd1);
      chk("t5_hold_inst", inst_o, I_ADDI);
      chk("t5_hold_op2", op2_o, 32'd5);
    end
    flush_i = 1'b1;
    drive(1'b1, 32'h408, I_JALR, 1'b1); #1;
    chk("t5_flush_ready", 32'(if_ready_o), 32'd0);
    tick();
    flush_i = 1'b0;
    chk("t5_flush_valid", 32'(ex_valid_o), 32'd0);
    chk("t5_flush_redirect", 32'(redirect_o), 32'd0);

    // 6: illegal encodings and x0 forwarding
    drive(1'b1, 32'h500, 32'hFFFFFFFF, 1'b1);
    tick();
    chk("t6_ones_illegal", 32'(illegal_o), 32'd1);
    chk("t6_ones_wreg", 32'(wreg_o), 32'd0);
    chk("t6_ones_aluop", 32'(aluop_o), 32'h00);
    chk("t6_ones_redirect", 32'(redirect_o), 32'd0);
    drive(1'b1, 32'h504, I_SLLB, 1'b1);
    tick();
    chk("t6_sllb_illegal", 32'(illegal_o), 32'd1);
    chk("t6_sllb_wreg", 32'(wreg_o), 32'd0);
    drive(1'b1, 32'h508, I_SLLI, 1'b1);
    tick();
    chk("t6_slli_legal", 32'(illegal_o), 32'd0);
    chk("t6_slli_aluop", 32'(aluop_o), 32'h7C);
    chk("t6_slli_imm", imm_o, 32'd3);
    drive(1'b1, 32'h50C, I_SRAI, 1'b1);
    tick();
    chk("t6_srai_aluop", 32'(aluop_o), 32'h03);
    chk("t6_srai_imm", imm_o, 32'd3);
    set_fwd(0, 1'b1, 5'd0, 32'hBEEF);
    set_fwd(1, 1'b1, 5'd1, 32'h77);
    rf_rdata1_i = 32'h99; rf_rdata2_i = 32'h88;
    drive(1'b1, 32'h510, I_ADDX0, 1'b1);
    tick();
    chk("t6_x0_op1", op1_o, 32'h0);
    chk("t6_x0_op2", op2_o, 32'h77);
    chk("t6_x0_legal", 32'(illegal_o), 32'd0);

    // Flush clears a pending load so the dependant is not stalled
    set_fwd(0, 1'b0, 5'd0, 32'h0); set_fwd(1, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 32'h600, I_LW, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b1, 32'h604, I_ADD3, 1'b1); #1;
    chk("ldflush_ready", 32'(if_ready_o), 32'd1);
    tick();

    // Asynchronous reset mid-operation
    drive(1'b1, 32'h700, I_ADDI, 1'b1);
    tick();
    chk("arst_pre_valid", 32'(ex_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ex_valid_o), 32'd0);
    chk("arst_op2", op2_o, 32'h0);
    chk("arst_aluop", 32'(aluop_o), 32'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
